// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA descriptor fetch engine: state and action
// encodings, descriptor bit positions and the decoded descriptor record.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FDS  = 2'd1,
    ST_CADR = 2'd2,
    ST_TFR  = 2'd3
  } adma_state_e;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_e;

  localparam int DESC_ADDR_LSB  = 32;
  localparam int DESC_LEN_LSB   = 16;
  localparam int DESC_ACT_LSB   = 4;
  localparam int DESC_INT_BIT   = 2;
  localparam int DESC_END_BIT   = 1;
  localparam int DESC_VALID_BIT = 0;

  // A zero length field means a full 64 KiB buffer.
  localparam logic [16:0] LEN_MAX = 17'h10000;

  typedef struct packed {
    logic [31:0] addr;
    logic [16:0] len;
    adma_act_e   act;
    logic        int_f;
    logic        end_f;
    logic        valid_f;
  } desc_fields_t;

  function automatic logic [16:0] expand_len(input logic [15:0] len_field);
    return (len_field == 16'h0000) ? LEN_MAX : {1'b0, len_field};
  endfunction

endpackage

// File: rtl/adma_desc_fetch_if.sv
// Descriptor memory read port plus the descriptor hand-off to the transfer
// stage; master is the fetch engine, slave is memory/transfer side.
interface adma_desc_fetch_if;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_addr;
  logic [16:0] desc_len;
  logic        desc_dir;
  logic        xfer_done;

  modport master (
    output mem_req, mem_addr, desc_valid, desc_addr, desc_len, desc_dir,
    input  mem_ack, mem_rdata, desc_ready, xfer_done
  );

  modport slave (
    input  mem_req, mem_addr, desc_valid, desc_addr, desc_len, desc_dir,
    output mem_ack, mem_rdata, desc_ready, xfer_done
  );

endinterface

// File: rtl/adma_desc_decode.sv
// Combinational split of a 64-bit ADMA descriptor into its fields, with
// length expansion and the aligned link target.
module adma_desc_decode
  import adma_pkg::*;
(
  input  logic [63:0]  desc,
  output desc_fields_t fields,
  output logic [63:0]  link_ptr
);

  logic unused_rsvd;

  always_comb begin
    fields.addr    = desc[DESC_ADDR_LSB +: 32];
    fields.len     = expand_len(desc[DESC_LEN_LSB +: 16]);
    fields.act     = adma_act_e'(desc[DESC_ACT_LSB +: 2]);
    fields.int_f   = desc[DESC_INT_BIT];
    fields.end_f   = desc[DESC_END_BIT];
    fields.valid_f = desc[DESC_VALID_BIT];
  end

  // Link targets are forced onto an 8-byte boundary in the low 4 GiB.
  assign link_ptr = {32'h0000_0000, desc[63:35], 3'b000};

  assign unused_rsvd = ^{desc[15:6], desc[3]};

endmodule

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetch engine: walks the descriptor table, follows links
// and hands transfer descriptors to the data transfer stage.
module adma_desc_fetch
  import adma_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     STOP,
  input  logic                     command_reg_write,
  input  logic                     command_reg_continue,
  input  logic                     direction,
  input  logic [63:0]              starting_address,
  adma_desc_fetch_if.master        bus,
  output logic [1:0]               adma_state,
  output logic                     done,
  output logic                     int_req,
  output logic                     adma_error
);

  adma_state_e  state;
  logic [63:0]  pointer;
  logic [63:0]  desc_reg;
  logic         dir_lat;
  logic         accepted;

  logic         mem_req_q;
  logic [63:0]  mem_addr_q;
  logic         desc_valid_q;
  logic [31:0]  desc_addr_q;
  logic [16:0]  desc_len_q;
  logic         desc_dir_q;

  desc_fields_t fields;
  logic [63:0]  link_ptr;
  logic [63:0]  seq_next;
  logic [63:0]  cadr_next;

  adma_desc_decode u_decode (
    .desc     (desc_reg),
    .fields   (fields),
    .link_ptr (link_ptr)
  );

  assign seq_next  = pointer + 64'd8;
  assign cadr_next = (fields.act == ACT_LINK) ? link_ptr : seq_next;

  // STOP overrides everything else in the same cycle; the pointer is left
  // untouched so a later continue refetches the interrupted descriptor.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_STOP;
      pointer      <= '0;
      desc_reg     <= '0;
      dir_lat      <= 1'b0;
      accepted     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      desc_valid_q <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      desc_dir_q   <= 1'b0;
      done         <= 1'b0;
      int_req      <= 1'b0;
      adma_error   <= 1'b0;
    end else begin
      done       <= 1'b0;
      int_req    <= 1'b0;
      adma_error <= 1'b0;
      if (STOP) begin
        state        <= ST_STOP;
        mem_req_q    <= 1'b0;
        desc_valid_q <= 1'b0;
        accepted     <= 1'b0;
      end else begin
        case (state)
          ST_STOP: begin
            if (command_reg_write) begin
              if (starting_address[2:0] != 3'b000) begin
                adma_error <= 1'b1;
              end else begin
                pointer    <= starting_address;
                dir_lat    <= direction;
                mem_addr_q <= starting_address;
                mem_req_q  <= 1'b1;
                state      <= ST_FDS;
              end
            end else if (command_reg_continue) begin
              mem_addr_q <= pointer;
              mem_req_q  <= 1'b1;
              state      <= ST_FDS;
            end
          end
          ST_FDS: begin
            if (bus.mem_ack) begin
              desc_reg  <= bus.mem_rdata;
              mem_req_q <= 1'b0;
              state     <= ST_CADR;
            end
          end
          ST_CADR: begin
            if (!fields.valid_f) begin
              adma_error <= 1'b1;
              state      <= ST_STOP;
            end else if (fields.act == ACT_TRAN) begin
              desc_valid_q <= 1'b1;
              desc_addr_q  <= fields.addr;
              desc_len_q   <= fields.len;
              desc_dir_q   <= dir_lat;
              accepted     <= 1'b0;
              state        <= ST_TFR;
            end else begin
              pointer <= cadr_next;
              if (fields.end_f) begin
                done  <= 1'b1;
                state <= ST_STOP;
              end else begin
                mem_addr_q <= cadr_next;
                mem_req_q  <= 1'b1;
                state      <= ST_FDS;
              end
            end
          end
          ST_TFR: begin
            // Completion only counts once the descriptor has been accepted.
            if (desc_valid_q && bus.desc_ready) begin
              desc_valid_q <= 1'b0;
              accepted     <= 1'b1;
            end else if (accepted && bus.xfer_done) begin
              pointer  <= seq_next;
              int_req  <= fields.int_f;
              accepted <= 1'b0;
              if (fields.end_f) begin
                done  <= 1'b1;
                state <= ST_STOP;
              end else begin
                mem_addr_q <= seq_next;
                mem_req_q  <= 1'b1;
                state      <= ST_FDS;
              end
            end
          end
          default: state <= ST_STOP;
        endcase
      end
    end
  end

  assign adma_state     = state;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.desc_valid = desc_valid_q;
  assign bus.desc_addr  = desc_addr_q;
  assign bus.desc_len   = desc_len_q;
  assign bus.desc_dir   = desc_dir_q;

endmodule

// File: doc/adma_desc_fetch.md
ADMA_DESC_FETCH -- requirements
Module: adma_desc_fetch

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 STOP  input  1  abort request; forces ST_STOP.
REQ-004 command_reg_write  input  1  start ADMA from starting_address.
REQ-005 command_reg_continue  input  1  resume from retained descriptor pointer.
REQ-006 direction  input  1  1=read from card, 0=write to card; latched per descriptor.
REQ-007 starting_address  input  64  descriptor table base, 8-byte aligned.
REQ-008 mem_req / mem_addr  output  1 / 64  descriptor read request and address.
REQ-009 mem_ack / mem_rdata  input  1 / 64  read completion and 64-bit descriptor.
REQ-010 desc_valid  output  1  transfer descriptor available to transfer stage.
REQ-011 desc_ready  input  1  transfer stage accepts descriptor.
REQ-012 desc_addr / desc_len / desc_dir  output  32 / 17 / 1  data buffer address, byte count, direction.
REQ-013 xfer_done  input  1  transfer stage finished current descriptor.
REQ-014 adma_state  output  2  ST_STOP=0, ST_FDS=1, ST_CADR=2, ST_TFR=3.
REQ-015 done / int_req / adma_error  output  1 each  single-cycle pulses.

Function
REQ-016 Descriptor fields: [63:32] address, [31:16] length, [5:4] act (00 nop, 01 rsv, 10 tran, 11 link), [2] int, [1] end, [0] valid.
REQ-017 desc_len = length field zero-extended; length 0 encodes 65536 (17'h10000).
REQ-018 ST_STOP: command_reg_write loads pointer=starting_address, latches direction, -> ST_FDS; command_reg_continue -> ST_FDS keeping pointer; command_reg_write wins if both.
REQ-019 starting_address[2:0] != 0 on start: adma_error pulse, stay ST_STOP.
REQ-020 ST_FDS: mem_req=1, mem_addr=pointer, held stable until mem_ack; on mem_ack latch mem_rdata, -> ST_CADR.
REQ-021 ST_CADR (one cycle): valid=0 -> adma_error, -> ST_STOP.
REQ-022 nop/rsv: pointer+=8; end -> done, ST_STOP; else -> ST_FDS.
REQ-023 link: pointer={32'h0, address[31:3], 3'b000}; end -> done, ST_STOP; else -> ST_FDS.
REQ-024 tran: -> ST_TFR, desc_valid=1 from next cycle.
REQ-025 ST_TFR: desc_valid held until cycle desc_ready=1, then deasserted; xfer_done counted only after acceptance.
REQ-026 On xfer_done: pointer+=8; int=1 -> int_req pulse; end=1 -> done pulse, ST_STOP; else -> ST_FDS.
REQ-027 Pointer arithmetic modulo 2^64; wrap silent.
REQ-028 STOP in any state -> ST_STOP next edge; mem_req, desc_valid drop; pointer retained, not advanced.
REQ-029 STOP same cycle as command_reg_write, mem_ack or xfer_done: STOP wins, event discarded.
REQ-030 command_reg_write/continue outside ST_STOP ignored.
REQ-031 Outputs registered; no combinational path input->output.

Reset
REQ-032 RESET asynchronously forces ST_STOP, pointer=0, descriptor register=0, all outputs 0.
REQ-033 RESET mid-fetch or mid-transfer abandons operation; no done/error pulse.

Structure
REQ-034 Shared package adma_pkg: state encodings, act codes, descriptor bit positions, LEN_MAX.
REQ-035 Sub-module adma_desc_decode: combinational field extraction and length expansion.

Verification
REQ-036 start=0x1000, desc@0x1000 = tran addr 0x2000 len 0x0200 end=1 valid=1 -> mem_addr 0x1000, desc_addr 0x2000, desc_len 512, done after xfer_done, ST_STOP.
REQ-037 desc@0x1000 link to 0x8000, desc@0x8000 tran len 0 end -> second mem_addr 0x8000, desc_len 65536.
REQ-038 desc valid=0 -> adma_error one cycle, ST_STOP, no desc_valid.
REQ-039 STOP asserted in ST_TFR before xfer_done, then command_reg_continue -> refetch same pointer.
REQ-040 desc_ready delayed 5 cycles, mem_ack delayed 3 -> desc_valid/mem_addr stable throughout; int=1 -> int_req one cycle.
REQ-041 RESET pulsed during ST_FDS -> all outputs 0 immediately, adma_state=0.
